// File: rtl/exec_issue_buf.sv
// exec_issue_buf: two-entry skid buffer between decode and the execute units.
// The head entry drives the exec bus. The skid entry absorbs one extra
// operation while exec stalls. Writeback results are forwarded into every
// operand that is held or being captured.
module exec_issue_buf #(
    parameter int W_OPR = 32,
    parameter int W_REG = 5,
    parameter int W_SEL = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W_OPR-1:0] in_opr0_i,
    input  logic [W_OPR-1:0] in_opr1_i,
    input  logic [W_REG-1:0] in_src0_i,
    input  logic [W_REG-1:0] in_src1_i,
    input  logic [W_SEL-1:0] in_select_i,
    input  logic [W_REG-1:0] in_dst_i,
    input  logic             wb_valid_i,
    input  logic [W_REG-1:0] wb_dst_i,
    input  logic [W_OPR-1:0] wb_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W_OPR-1:0] opr0_o,
    output logic [W_OPR-1:0] opr1_o,
    output logic [W_SEL-1:0] select_o,
    output logic [W_REG-1:0] dst_o
);

    typedef struct packed {
        logic             valid;
        logic [W_SEL-1:0] select;
        logic [W_REG-1:0] dst;
        logic [W_REG-1:0] src0;
        logic [W_REG-1:0] src1;
        logic [W_OPR-1:0] opr0;
        logic [W_OPR-1:0] opr1;
    } entry_t;

    entry_t head_p0, skid_p0;
    entry_t head_nxt, skid_nxt;
    entry_t head_fwd, skid_fwd, in_fwd, in_entry;
    logic   issue, accept;

    // Replace any operand whose source matches the writeback destination.
    // Register 0 is hard-wired, so a writeback to index 0 never forwards.
    function automatic entry_t forward(input entry_t           e,
                                       input logic             wv,
                                       input logic [W_REG-1:0] wd,
                                       input logic [W_OPR-1:0] wdata);
        entry_t r;
        r = e;
        if (wv && (wd != '0)) begin
            if (e.src0 == wd) r.opr0 = wdata;
            if (e.src1 == wd) r.opr1 = wdata;
        end
        return r;
    endfunction

    assign issue  = head_p0.valid & out_ready_i;
    assign accept = in_valid_i & ~skid_p0.valid;

    // Next-state selection: flush first, then refill head from skid or input.
    always_comb begin
        in_entry        = '0;
        in_entry.valid  = 1'b1;
        in_entry.select = in_select_i;
        in_entry.dst    = in_dst_i;
        in_entry.src0   = in_src0_i;
        in_entry.src1   = in_src1_i;
        in_entry.opr0   = in_opr0_i;
        in_entry.opr1   = in_opr1_i;

        head_fwd = forward(head_p0, wb_valid_i, wb_dst_i, wb_data_i);
        skid_fwd = forward(skid_p0, wb_valid_i, wb_dst_i, wb_data_i);
        in_fwd   = forward(in_entry, wb_valid_i, wb_dst_i, wb_data_i);

        head_nxt = head_fwd;
        skid_nxt = skid_fwd;

        if (flush_i) begin
            head_nxt.valid = 1'b0;
            skid_nxt.valid = 1'b0;
        end else if (!head_p0.valid || issue) begin
            // The skid entry is always older than the incoming operation.
            if (skid_p0.valid) begin
                head_nxt = skid_fwd;
            end else if (accept) begin
                head_nxt = in_fwd;
            end else begin
                head_nxt.valid = 1'b0;
            end
            skid_nxt.valid = 1'b0;
        end else if (accept) begin
            skid_nxt = in_fwd;
        end
    end

    // Entry registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_p0 <= '0;
            skid_p0 <= '0;
        end else begin
            head_p0 <= head_nxt;
            skid_p0 <= skid_nxt;
        end
    end

    assign in_ready_o  = ~skid_p0.valid;
    assign out_valid_o = head_p0.valid;
    assign opr0_o      = head_p0.opr0;
    assign opr1_o      = head_p0.opr1;
    assign select_o    = head_p0.select;
    assign dst_o       = head_p0.dst;

endmodule

// File: tb/tb_exec_issue_buf.sv
// Testbench for exec_issue_buf: a directed vector table, hand-written
// streaming/reset sequences, and a randomized run against a queue model.
module tb_exec_issue_buf;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, wb_valid;
    logic [31:0] in_opr0, in_opr1, wb_data;
    logic [4:0]  in_src0, in_src1, in_dst, wb_dst;
    logic [1:0]  in_sel;
    logic        in_ready, out_valid;
    logic [31:0] opr0, opr1;
    logic [1:0]  select;
    logic [4:0]  dst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_issue_buf dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_opr0_i(in_opr0), .in_opr1_i(in_opr1),
        .in_src0_i(in_src0), .in_src1_i(in_src1),
        .in_select_i(in_sel), .in_dst_i(in_dst),
        .wb_valid_i(wb_valid), .wb_dst_i(wb_dst), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .opr0_o(opr0), .opr1_o(opr1), .select_o(select), .dst_o(dst)
    );

    // Reference model: ordered queue of pending operations, head first.
    typedef struct {
        logic [31:0] opr0, opr1;
        logic [4:0]  src0, src1, dst;
        logic [1:0]  sel;
    } op_t;
    op_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic op_t mfwd(input op_t o);
        op_t r;
        r = o;
        if (wb_valid && wb_dst != 5'd0) begin
            if (o.src0 == wb_dst) r.opr0 = wb_data;
            if (o.src1 == wb_dst) r.opr1 = wb_data;
        end
        return r;
    endfunction

    task automatic model_edge();
        int  n;
        bit  rdy, iss, acc;
        op_t o;
        n   = mq.size();
        rdy = (n < 2);
        iss = (n > 0) && out_ready;
        acc = in_valid && rdy;
        if (flush) begin
            mq.delete();
        end else begin
            if (iss) void'(mq.pop_front());
            for (int i = 0; i < mq.size(); i++) mq[i] = mfwd(mq[i]);
            if (acc) begin
                o.opr0 = in_opr0; o.opr1 = in_opr1;
                o.src0 = in_src0; o.src1 = in_src1;
                o.dst  = in_dst;  o.sel  = in_sel;
                mq.push_back(mfwd(o));
            end
        end
    endtask

    task automatic model_cmp(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk({tag, "_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            chk({tag, "_opr0"}, opr0, mq[0].opr0);
            chk({tag, "_opr1"}, opr1, mq[0].opr1);
            chk({tag, "_sel"}, {30'd0, select}, {30'd0, mq[0].sel});
            chk({tag, "_dst"}, {27'd0, dst}, {27'd0, mq[0].dst});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_op(input logic [31:0] o0, input logic [31:0] o1,
                            input logic [4:0] s0, input logic [4:0] s1,
                            input logic [1:0] sl, input logic [4:0] d);
        in_opr0 = o0; in_opr1 = o1; in_src0 = s0; in_src1 = s1; in_sel = sl; in_dst = d;
    endtask

    typedef struct {
        logic        iv, ordy, fl, wv;
        logic [31:0] o0, o1, wdat;
        logic [4:0]  s0, s1, d, wd;
        logic [1:0]  sl;
        logic        ev, er, cd;
        logic [31:0] e0, e1;
        logic [1:0]  es;
        logic [4:0]  ed;
    } vec_t;
    vec_t tbl[14];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [31:0] o0, input logic [31:0] o1,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] sl, input logic [4:0] d,
                                input logic wv, input logic [4:0] wd, input logic [31:0] wdat,
                                input logic ev, input logic er, input logic cd,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] es, input logic [4:0] ed);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.o0 = o0; v.o1 = o1; v.s0 = s0; v.s1 = s1;
        v.sl = sl; v.d = d; v.wv = wv; v.wd = wd; v.wdat = wdat;
        v.ev = ev; v.er = er; v.cd = cd; v.e0 = e0; v.e1 = e1; v.es = es; v.ed = ed;
        return v;
    endfunction

    initial begin
        //              iv ordy fl  opr0   opr1   s0 s1 sl  d  wv wd wdata   ev er cd  e0     e1     es ed
        tbl[0]  = mk(1, 0, 0, 32'h11, 32'h22, 3, 4, 1, 5, 0, 0, 0,      1, 1, 1, 32'h11, 32'h22, 1, 5);
        tbl[1]  = mk(1, 0, 0, 32'h33, 32'h44, 6, 7, 2, 8, 0, 0, 0,      1, 0, 1, 32'h11, 32'h22, 1, 5);
        tbl[2]  = mk(1, 0, 0, 32'h55, 32'h66, 9,10, 3,11, 0, 0, 0,      1, 0, 1, 32'h11, 32'h22, 1, 5);
        tbl[3]  = mk(1, 1, 0, 32'h55, 32'h66, 9,10, 3,11, 0, 0, 0,      1, 1, 1, 32'h33, 32'h44, 2, 8);
        tbl[4]  = mk(1, 0, 0, 32'h55, 32'h66, 9,10, 3,11, 0, 0, 0,      1, 0, 1, 32'h33, 32'h44, 2, 8);
        tbl[5]  = mk(0, 1, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0,      1, 1, 1, 32'h55, 32'h66, 3,11);
        tbl[6]  = mk(0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 1, 9, 32'hAB, 1, 1, 1, 32'hAB, 32'h66, 3,11);
        tbl[7]  = mk(1, 1, 0, 32'h77, 32'h05, 0, 7, 0,12, 1, 7, 32'h99, 1, 1, 1, 32'h77, 32'h99, 0,12);
        tbl[8]  = mk(0, 0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 1, 0, 32'hEE, 1, 1, 1, 32'h77, 32'h99, 0,12);
        tbl[9]  = mk(1, 0, 0, 32'h1,  32'h2,  1, 2, 1,13, 0, 0, 0,      1, 0, 1, 32'h77, 32'h99, 0,12);
        tbl[10] = mk(1, 1, 1, 32'h3,  32'h4,  1, 2, 2,14, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 0, 32'h9,  32'hA,  3, 4, 2,15, 0, 0, 0,      1, 1, 1, 32'h9,  32'hA,  2,15);
        tbl[13] = mk(0, 1, 0, 32'h0,  32'h0,  0, 0, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0;
        wb_dst = '0; wb_data = '0;
        drive_op(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_opr0", opr0, 32'd0);
        chk("rst_opr1", opr1, 32'd0);
        chk("rst_sel", {30'd0, select}, 32'd0);
        chk("rst_dst", {27'd0, dst}, 32'd0);
        rst = 1'b0;
        cyc();

        // Directed vectors: back-pressure, forwarding, flush.
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
            drive_op(tbl[i].o0, tbl[i].o1, tbl[i].s0, tbl[i].s1, tbl[i].sl, tbl[i].d);
            wb_valid = tbl[i].wv; wb_dst = tbl[i].wd; wb_data = tbl[i].wdat;
            cyc();
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
            if (tbl[i].cd) begin
                chk($sformatf("vec%0d_opr0", i), opr0, tbl[i].e0);
                chk($sformatf("vec%0d_opr1", i), opr1, tbl[i].e1);
                chk($sformatf("vec%0d_sel", i), {30'd0, select}, {30'd0, tbl[i].es});
                chk($sformatf("vec%0d_dst", i), {27'd0, dst}, {27'd0, tbl[i].ed});
            end
        end
        flush = 1'b0; wb_valid = 1'b0;

        // Streaming: one op per cycle, ready never drops.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_op(32'h100 + i, 32'h200 + i, 5'(i + 1), 5'(i + 9), 2'(i), 5'(i + 16));
            cyc();
            model_cmp("stream");
            chk("stream_rdy", {31'd0, in_ready}, 32'd1);
            chk("stream_dst", {27'd0, dst}, 32'(i + 16));
        end

        // Async reset between edges clears outputs immediately.
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_opr0", opr0, 32'd0);
        chk("arst_opr1", opr1, 32'd0);
        chk("arst_sel", {30'd0, select}, 32'd0);
        chk("arst_dst", {27'd0, dst}, 32'd0);
        #2;
        rst = 1'b0;
        mq.delete();
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h300 + i, 32'h400 + i, 5'(i + 2), 5'(i + 3), 2'(i), 5'(i + 20));
            cyc();
            model_cmp("post_rst");
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            wb_valid  = ($urandom_range(0, 1) != 0);
            wb_dst    = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            drive_op($urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            cyc();
            model_cmp("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
